// File: rtl/count_ctrl_pkg.sv
// Shared types and pin-map constants for the start/stop counter initiator.
package count_ctrl_pkg;
  localparam int CNT_W     = 8;
  localparam int LEN_W     = 5;
  localparam int GO_BIT    = 2;
  localparam int LEN_LSB   = 3;
  localparam int START_BIT = 0;
  localparam int STOP_BIT  = 1;

  typedef enum logic [2:0] {IDLE, SNAP, RUN, HOLD, DRAIN, DONE} state_e;

  // A programmed length of 0 encodes the maximum run of 32 starts.
  function automatic logic [5:0] run_len(input logic [LEN_W-1:0] n);
    return (n == '0) ? 6'd32 : {1'b0, n};
  endfunction
endpackage

// File: rtl/count_ctrl_if.sv
// Link between the sequencer and the readback checker.
interface count_ctrl_if #(parameter int ERR_W = 4) ();
  import count_ctrl_pkg::*;
  logic             push;
  logic [CNT_W-1:0] exp;
  logic             flush;
  logic             clr;
  logic [ERR_W-1:0] err_cnt;
  logic             overflow;

  modport master (output push, exp, flush, clr, input err_cnt, overflow);
  modport slave  (input push, exp, flush, clr, output err_cnt, overflow);
endinterface

// File: rtl/count_ctrl_chk.sv
// Expected-value delay line (RD_LAT deep) and saturating mismatch counter.
module count_ctrl_chk import count_ctrl_pkg::*; #(
  parameter int RD_LAT = 1,
  parameter int ERR_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] act,
  count_ctrl_if.slave      bus
);
  logic [RD_LAT:1]            vld_pipe;
  logic [RD_LAT:1][CNT_W-1:0] exp_pipe;
  logic [ERR_W-1:0]           err_cnt;
  logic                       sat, miss;

  assign sat  = &err_cnt;
  assign miss = vld_pipe[RD_LAT] && (act != exp_pipe[RD_LAT]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      exp_pipe <= '0;
    end else if (bus.flush) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[1] <= bus.push;
      exp_pipe[1] <= bus.exp;
      for (int i = 2; i <= RD_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        exp_pipe[i] <= exp_pipe[i-1];
      end
    end
  end

  // An abort discards whatever is emerging that cycle as well.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         err_cnt <= '0;
    else if (bus.clr)                   err_cnt <= '0;
    else if (miss && !bus.flush && !sat) err_cnt <= err_cnt + 1'b1;
  end

  assign bus.err_cnt  = err_cnt;
  assign bus.overflow = sat;
endmodule

// File: rtl/tt_um_count_ctrl.sv
// Start/stop counter initiator: sequences pulses, checks readback, reports pass/errors.
// Optional COUNT_CTRL_FREERUN_EN: DONE loops back to SNAP while go stays high.
module tt_um_count_ctrl import count_ctrl_pkg::*; #(
  parameter int RD_LAT   = 1,
  parameter int HOLD_CYC = 4,
  parameter int ERR_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  output logic [7:0] uo_out
);
  localparam logic [5:0] HOLD_END  = 6'(HOLD_CYC);
  localparam logic [5:0] DRAIN_END = 6'(RD_LAT);

  state_e           state, state_d;
  logic [LEN_W-1:0] len_q;
  logic [CNT_W-1:0] base_q;
  logic [5:0]       ph, n_eff;
  logic             start_q, stop_q, done_q, abort, go, busy, pass;
  logic             unused_pins;

  assign go          = uio_in[GO_BIT];
  assign n_eff       = run_len(len_q);
  assign busy        = state inside {SNAP, RUN, HOLD, DRAIN};
  assign unused_pins = &{1'b0, ena, uio_in[1:0]};

  always_comb begin
    state_d = state;
    abort   = 1'b0;
    case (state)
      IDLE:  if (go) state_d = SNAP;
      SNAP:  state_d = RUN;
      RUN:   if (ph == n_eff) state_d = HOLD;
      HOLD:  if (ph == HOLD_END) state_d = DRAIN;
      DRAIN: if (ph == DRAIN_END) state_d = DONE;
      DONE: begin
`ifdef COUNT_CTRL_FREERUN_EN
        state_d = go ? SNAP : IDLE;
`else
        if (!go) state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
    if (busy && !go) begin
      state_d = IDLE;
      abort   = 1'b1;
    end
  end

  // ph counts 1.. within each timed phase; restarts on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ph      <= 6'd1;
      len_q   <= '0;
      base_q  <= '0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_d;
      ph      <= (state_d != state) ? 6'd1 : ph + 6'd1;
      start_q <= (state_d == RUN);
      stop_q  <= (state_d == HOLD);
      if (state == IDLE && go) len_q  <= uio_in[7:LEN_LSB];
      if (state == SNAP)       base_q <= ui_in;
      if (state_d == SNAP)      done_q <= 1'b0;
      else if (state_d == DONE) done_q <= 1'b1;
    end
  end

  count_ctrl_if #(.ERR_W(ERR_W)) chk_if ();

  assign chk_if.push  = (state == RUN) || (state == HOLD);
  assign chk_if.exp   = base_q + CNT_W'((state == RUN) ? ph : n_eff);
  assign chk_if.flush = abort;
  assign chk_if.clr   = (state == IDLE) && go;

  count_ctrl_chk #(.RD_LAT(RD_LAT), .ERR_W(ERR_W)) u_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .act   (ui_in),
    .bus   (chk_if.slave)
  );

  assign pass    = done_q && (chk_if.err_cnt == '0);
  assign uo_out  = {chk_if.overflow, pass, done_q, busy, 4'(chk_if.err_cnt)};
  assign uio_out = {6'b0, stop_q, start_q};
  assign uio_oe  = 8'h03;
endmodule

// File: tb/tb_tt_um_count_ctrl.sv
// Bench: registered start/stop counter model with fault hooks, scoreboard on end-of-run.
module tb_tt_um_count_ctrl;
  logic       clk = 1'b0, rst_n = 1'b0, ena = 1'b1;
  logic [7:0] ui_in, uio_in = 8'h00, uio_out, uio_oe, uo_out;
  logic [7:0] cnt = 8'h00, ld_val = 8'h00;
  logic       ld = 1'b0, stuck2 = 1'b0, frozen = 1'b0;
  logic       busy_prev = 1'b0;
  int         checks = 0, failures = 0;

  typedef struct packed { logic [7:0] ui; logic [7:0] uo; logic [7:0] uio; } resp_t;
  resp_t sb_q[$];

  always #5 clk = ~clk;

  assign ui_in = stuck2 ? (cnt & 8'hFB) : cnt;
  always @(posedge clk)
    if (ld) cnt <= ld_val;
    else if (uio_out[0] && !frozen) cnt <= cnt + 8'd1;

  tt_um_count_ctrl #(.RD_LAT(1), .HOLD_CYC(4), .ERR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uio_out(uio_out), .uio_oe(uio_oe), .uo_out(uo_out)
  );

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // End of a run (DONE, abort or reset) shows up as busy falling.
  always @(negedge clk) begin
    resp_t e;
    if (busy_prev && !uo_out[4]) begin
      if (sb_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL sb_unexpected: got ui=%h uo=%h expected no event", ui_in, uo_out);
      end else begin
        e = sb_q.pop_front();
        check8("sb_ui", ui_in, e.ui);
        check8("sb_uo", uo_out, e.uo);
        check8("sb_uio", uio_out, e.uio);
      end
    end
    busy_prev <= uo_out[4];
  end

  always @(negedge clk)
    if (uio_out[0] && uio_out[1]) begin
      failures++;
      $display("FAIL start_stop_overlap: got uio_out=%h expected one-hot", uio_out);
    end

  task automatic load(input logic [7:0] v);
    @(negedge clk); ld_val = v; ld = 1'b1;
    @(negedge clk); ld = 1'b0;
  endtask

  task automatic run(input string name, input logic [4:0] n, input logic [7:0] eui, input logic [7:0] euo);
    bit seen = 1'b0;
    sb_q.push_back({eui, euo, 8'h00});
    uio_in = {n, 1'b1, 2'b00};
    @(negedge clk);
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (uo_out[5]) begin seen = 1'b1; break; end
    end
    uio_in = 8'h00;
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s_timeout: got no done expected done within 300 cycles", name);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    check8("rst_uo", uo_out, 8'h00);
    check8("rst_uio", uio_out, 8'h00);
    check8("rst_oe", uio_oe, 8'h03);
    rst_n = 1'b1;

    load(8'h10);
    run("base10_n3", 5'd3, 8'h13, 8'h60);
    repeat (2) @(negedge clk);
    check8("done_hold_idle", uo_out, 8'h60);

    load(8'hF0);
    run("wrap_n32", 5'd0, 8'h10, 8'h60);

    stuck2 = 1'b1;
    load(8'h00);
    run("stuck_bit2", 5'd8, 8'h08, 8'h24);
    stuck2 = 1'b0;

    frozen = 1'b1;
    load(8'h00);
    run("saturate", 5'd16, 8'h00, 8'hAF);
    frozen = 1'b0;

    // abort on the second RUN cycle
    load(8'h40);
    sb_q.push_back({8'h42, 8'h00, 8'h00});
    uio_in = 8'h44;
    repeat (3) @(negedge clk);
    check8("abort_run2_start", uio_out, 8'h01);
    uio_in = 8'h00;
    @(negedge clk);
    check8("abort_uo", uo_out, 8'h00);
    repeat (2) @(negedge clk);

    // async reset in the middle of HOLD
    load(8'h20);
    sb_q.push_back({8'h22, 8'h00, 8'h00});
    uio_in = 8'h14;
    repeat (5) @(negedge clk);
    check8("hold_stop", uio_out, 8'h02);
    #2 rst_n = 1'b0;
    #1;
    check8("async_rst_uo", uo_out, 8'h00);
    check8("async_rst_uio", uio_out, 8'h00);
    uio_in = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run("post_reset", 5'd1, 8'h23, 8'h60);

`ifdef COUNT_CTRL_FREERUN_EN
    begin
      int nd = 0;
      load(8'h50);
      sb_q.push_back({8'h52, 8'h60, 8'h00});
      sb_q.push_back({8'h54, 8'h60, 8'h00});
      sb_q.push_back({8'h56, 8'h60, 8'h00});
      uio_in = 8'h14;
      @(negedge clk);
      for (int c = 0; c < 200; c++) begin
        @(negedge clk);
        if (uo_out[5]) begin
          nd++;
          if (nd == 3) begin uio_in = 8'h00; break; end
        end
      end
      uio_in = 8'h00;
      checks++;
      if (nd != 3) begin
        failures++;
        $display("FAIL freerun_passes: got %0d expected 3", nd);
      end
    end
`endif

    repeat (3) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover: got %0d pending expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
